// File: rtl/rc_pwm_capture_pkg.sv
// Shared constants for the RC/servo PWM capture slave:
// register map, bit positions, FSM encoding and counter helper.
package rc_pwm_capture_pkg;

  localparam logic [2:0] ADDR_ID     = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_WIDTH  = 3'd2;
  localparam logic [2:0] ADDR_PERIOD = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;

  localparam int ST_WV  = 0;
  localparam int ST_PV  = 1;
  localparam int ST_TO  = 2;
  localparam int ST_NEW = 3;
  localparam int ST_LVL = 4;

  localparam logic [31:0] DEF_ID_VALUE = 32'hEA68_0004;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RISE,
    S_HIGH,
    S_LOW
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rc_pwm_capture_edge.sv
// Pin synchroniser, optional inversion and edge detect.
// Fixed pin-to-edge latency, so it cancels out of all measurements.
module pwm_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  input  logic i_inv,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_s;

  assign w_s = r_sync2 ^ i_inv;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      r_prev  <= w_s;
    end
  end

  assign o_s    = w_s;
  assign o_rise = w_s & ~r_prev;
  assign o_fall = ~w_s & r_prev;

endmodule

// File: rtl/rc_pwm_capture.sv
// Avalon-MM slave measuring high-time and period of an RC PWM input,
// with sticky timeout and new-sample flags.
module rc_pwm_capture
  import rc_pwm_capture_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd5_000_000,
  parameter logic [31:0] ID_VALUE       = DEF_ID_VALUE
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [31:0] avs_ctrl_writedata,
  output logic [31:0] avs_ctrl_readdata,
  input  logic [3:0]  avs_ctrl_byteenable,
  input  logic [2:0]  avs_ctrl_address,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  output logic        avs_ctrl_waitrequest,
  input  logic        coe_pwm_in
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_en;
  logic        r_inv;
  logic        r_wv;
  logic        r_pv;
  logic        r_to;
  logic        r_new;
  logic [31:0] r_width;
  logic [31:0] r_period;
  logic [31:0] r_hcnt;
  logic [31:0] r_pcnt;
  logic [31:0] r_idle;
  logic [31:0] r_readdata;
  logic [31:0] w_rdata;

  logic w_s;
  logic w_rise;
  logic w_fall;
  logic w_wr_ctrl;
  logic w_wr_stat;
  logic w_en_nxt;
  logic w_idle_hit;
  logic w_tout;
  logic w_lat_w;
  logic w_lat_p;
  logic w_restart;
  logic w_unused;

  pwm_edge_sync u_sync (
    .i_clk  (csi_MCLK_clk),
    .i_rst  (rsi_MRST_reset),
    .i_pin  (coe_pwm_in),
    .i_inv  (r_inv),
    .o_s    (w_s),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_wr_ctrl = avs_ctrl_write && avs_ctrl_byteenable[0]
                  && (avs_ctrl_address == ADDR_CTRL);
  assign w_wr_stat = avs_ctrl_write && avs_ctrl_byteenable[0]
                  && (avs_ctrl_address == ADDR_STATUS);
  assign w_en_nxt  = w_wr_ctrl ? avs_ctrl_writedata[CTRL_EN] : r_en;

  assign w_idle_hit = (r_state != S_IDLE) && !w_rise && !w_fall
                   && (r_idle >= TIMEOUT_CYCLES - 32'd1);

  // A disabling write takes effect on this edge, so an edge seen now is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_tout      = 1'b0;
    w_lat_w     = 1'b0;
    w_lat_p     = 1'b0;
    w_restart   = 1'b0;
    if (!r_en || !w_en_nxt) begin
      w_state_nxt = S_IDLE;
    end else if (r_state == S_IDLE) begin
      w_state_nxt = S_WAIT_RISE;
    end else if (w_idle_hit) begin
      w_tout      = 1'b1;
      w_state_nxt = S_WAIT_RISE;
    end else begin
      unique case (r_state)
        S_WAIT_RISE: if (w_rise) begin
          w_restart   = 1'b1;
          w_state_nxt = S_HIGH;
        end
        S_HIGH: if (w_fall) begin
          w_lat_w     = 1'b1;
          w_state_nxt = S_LOW;
        end
        S_LOW: if (w_rise) begin
          w_lat_p     = 1'b1;
          w_restart   = 1'b1;
          w_state_nxt = S_HIGH;
        end
        S_IDLE: ;
      endcase
    end
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) r_state <= S_IDLE;
    else                r_state <= w_state_nxt;
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_hcnt <= '0;
      r_pcnt <= '0;
      r_idle <= '0;
    end else if (w_state_nxt == S_IDLE || w_tout) begin
      r_hcnt <= '0;
      r_pcnt <= '0;
      r_idle <= '0;
    end else begin
      if (w_rise || w_fall)        r_idle <= '0;
      else if (r_state != S_IDLE)  r_idle <= sat_inc(r_idle);
      if (w_restart) begin
        r_hcnt <= 32'd1;
        r_pcnt <= 32'd1;
      end else begin
        if (r_state == S_HIGH) r_hcnt <= sat_inc(r_hcnt);
        if (r_state == S_HIGH || r_state == S_LOW)
          r_pcnt <= sat_inc(r_pcnt);
      end
    end
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_en     <= 1'b0;
      r_inv    <= 1'b0;
      r_width  <= '0;
      r_period <= '0;
      r_wv     <= 1'b0;
      r_pv     <= 1'b0;
      r_to     <= 1'b0;
      r_new    <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en  <= avs_ctrl_writedata[CTRL_EN];
        r_inv <= avs_ctrl_writedata[CTRL_INV];
      end
      if (w_lat_w) r_width  <= r_hcnt;
      if (w_lat_p) r_period <= r_pcnt;
      if (w_tout)       r_wv <= 1'b0;
      else if (w_lat_w) r_wv <= 1'b1;
      if (w_tout)       r_pv <= 1'b0;
      else if (w_lat_p) r_pv <= 1'b1;
      // Hardware set beats a simultaneous write-1-to-clear.
      if (w_tout)
        r_to <= 1'b1;
      else if (w_wr_stat && avs_ctrl_writedata[ST_TO])
        r_to <= 1'b0;
      if (w_lat_w)
        r_new <= 1'b1;
      else if (w_wr_stat && avs_ctrl_writedata[ST_NEW])
        r_new <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      (avs_ctrl_address == ADDR_ID):     w_rdata = ID_VALUE;
      (avs_ctrl_address == ADDR_CTRL):   w_rdata = {30'd0, r_inv, r_en};
      (avs_ctrl_address == ADDR_WIDTH):  w_rdata = r_width;
      (avs_ctrl_address == ADDR_PERIOD): w_rdata = r_period;
      (avs_ctrl_address == ADDR_STATUS):
        w_rdata = {27'd0, w_s, r_new, r_to, r_pv, r_wv};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset)     r_readdata <= '0;
    else if (avs_ctrl_read) r_readdata <= w_rdata;
  end

  assign avs_ctrl_readdata    = r_readdata;
  assign avs_ctrl_waitrequest = 1'b0;
  assign w_unused = ^{avs_ctrl_writedata[31:4], avs_ctrl_writedata[1:0],
                      avs_ctrl_byteenable[3:1]};

endmodule

// File: tb/tb_rc_pwm_capture.sv
// Directed bench for rc_pwm_capture; timeout shortened to 1000 cycles
// and waveforms scaled so the run stays short.
module tb_rc_pwm_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wd = '0;
  logic [31:0] rdata;
  logic [3:0]  be = '0;
  logic [2:0]  addr = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic        waitreq;
  logic        pin = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rc_pwm_capture #(
    .TIMEOUT_CYCLES (32'd1000),
    .ID_VALUE       (32'hEA68_0004)
  ) dut (
    .csi_MCLK_clk         (clk),
    .rsi_MRST_reset       (rst),
    .avs_ctrl_writedata   (wd),
    .avs_ctrl_readdata    (rdata),
    .avs_ctrl_byteenable  (be),
    .avs_ctrl_address     (addr),
    .avs_ctrl_write       (wr),
    .avs_ctrl_read        (rd),
    .avs_ctrl_waitrequest (waitreq),
    .coe_pwm_in           (pin)
  );

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d,
                        input logic [3:0] b);
    addr = a; wd = d; be = b; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0; be = 4'h0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; pin = 1'b0;
    wait_cyc(3);
    total++;
    if (rdata !== 32'd0) begin
      bad++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'd0);
    end
    total++;
    if (waitreq !== 1'b0) begin
      bad++; $display("FAIL waitreq got=%b exp=0", waitreq);
    end
    rst = 1'b0;
    wait_cyc(2);
    addr = 3'd0; rd = 1'b1;
    #2;
    total++;
    if (rdata !== 32'd0) begin
      bad++; $display("FAIL rd_latency_early got=%h exp=%h", rdata, 32'd0);
    end
    @(posedge clk); #1;
    rd = 1'b0;
    total++;
    if (rdata !== 32'hEA68_0004) begin
      bad++; $display("FAIL id got=%h exp=%h", rdata, 32'hEA68_0004);
    end
    addr = 3'd1;
    wait_cyc(2);
    total++;
    if (rdata !== 32'hEA68_0004) begin
      bad++; $display("FAIL rd_hold got=%h exp=%h", rdata, 32'hEA68_0004);
    end
    rd_reg(3'd1, v);
    total++;
    if (v !== 32'd0) begin
      bad++; $display("FAIL ctrl_reset got=%h exp=%h", v, 32'd0);
    end
    wr_reg(3'd1, 32'h3, 4'b1110);
    rd_reg(3'd1, v);
    total++;
    if (v !== 32'd0) begin
      bad++; $display("FAIL ctrl_byteen got=%h exp=%h", v, 32'd0);
    end
    wr_reg(3'd5, 32'hFFFF_FFFF, 4'hF);
    rd_reg(3'd5, v);
    total++;
    if (v !== 32'd0) begin
      bad++; $display("FAIL addr5 got=%h exp=%h", v, 32'd0);
    end
  endtask

  task automatic test_enable_high();
    logic [31:0] v;
    pin = 1'b1;
    wait_cyc(5);
    wr_reg(3'd1, 32'h1, 4'hF);
    wait_cyc(200);
    pin = 1'b0;
    wait_cyc(100);
    rd_reg(3'd2, v);
    total++;
    if (v !== 32'd0) begin
      bad++; $display("FAIL en_high_width got=%0d exp=%0d", v, 0);
    end
    rd_reg(3'd4, v);
    total++;
    if (v !== 32'h0) begin
      bad++; $display("FAIL en_high_status got=%h exp=%h", v, 32'h0);
    end
    pin = 1'b1;
    wait_cyc(100);
    pin = 1'b0;
    wait_cyc(10);
    rd_reg(3'd2, v);
    total++;
    if (v !== 32'd100) begin
      bad++; $display("FAIL first_width got=%0d exp=%0d", v, 100);
    end
    rd_reg(3'd4, v);
    total++;
    if (v !== 32'h9) begin
      bad++; $display("FAIL first_status got=%h exp=%h", v, 32'h9);
    end
    rd_reg(3'd3, v);
    total++;
    if (v !== 32'd0) begin
      bad++; $display("FAIL first_period got=%0d exp=%0d", v, 0);
    end
  endtask

  task automatic test_measure();
    logic [31:0] v;
    wr_reg(3'd1, 32'h0, 4'hF);
    wr_reg(3'd4, 32'hC, 4'hF);
    wr_reg(3'd1, 32'h1, 4'hF);
    wait_cyc(5);
    for (int i = 0; i < 3; i++) begin
      pin = 1'b1;
      wait_cyc(75);
      pin = 1'b0;
      wait_cyc(925);
    end
    rd_reg(3'd2, v);
    total++;
    if (v !== 32'd75) begin
      bad++; $display("FAIL meas_width got=%0d exp=%0d", v, 75);
    end
    rd_reg(3'd3, v);
    total++;
    if (v !== 32'd1000) begin
      bad++; $display("FAIL meas_period got=%0d exp=%0d", v, 1000);
    end
    rd_reg(3'd4, v);
    total++;
    if (v !== 32'hB) begin
      bad++; $display("FAIL meas_status got=%h exp=%h", v, 32'hB);
    end
    wr_reg(3'd1, 32'h0, 4'hF);
  endtask

  task automatic test_invert();
    logic [31:0] v;
    wr_reg(3'd1, 32'h2, 4'hF);
    wait_cyc(5);
    wr_reg(3'd1, 32'h3, 4'hF);
    wait_cyc(5);
    for (int i = 0; i < 3; i++) begin
      pin = 1'b1;
      wait_cyc(100);
      pin = 1'b0;
      wait_cyc(300);
    end
    rd_reg(3'd2, v);
    total++;
    if (v !== 32'd300) begin
      bad++; $display("FAIL inv_width got=%0d exp=%0d", v, 300);
    end
    rd_reg(3'd3, v);
    total++;
    if (v !== 32'd400) begin
      bad++; $display("FAIL inv_period got=%0d exp=%0d", v, 400);
    end
    rd_reg(3'd4, v);
    total++;
    if (v !== 32'h1B) begin
      bad++; $display("FAIL inv_status got=%h exp=%h", v, 32'h1B);
    end
    wr_reg(3'd1, 32'h0, 4'hF);
  endtask

  task automatic test_timeout();
    logic [31:0] v;
    bit          seen;
    wr_reg(3'd4, 32'hC, 4'hF);
    pin = 1'b0;
    wr_reg(3'd1, 32'h1, 4'hF);
    wait_cyc(5);
    pin = 1'b1;
    wait_cyc(50);
    pin = 1'b0;
    wait_cyc(994);
    rd_reg(3'd4, v);
    total++;
    if (v !== 32'hB) begin
      bad++; $display("FAIL to_early got=%h exp=%h", v, 32'hB);
    end
    wait_cyc(14);
    rd_reg(3'd4, v);
    total++;
    if (v !== 32'hC) begin
      bad++; $display("FAIL to_set got=%h exp=%h", v, 32'hC);
    end
    rd_reg(3'd2, v);
    total++;
    if (v !== 32'd50) begin
      bad++; $display("FAIL to_stale_width got=%0d exp=%0d", v, 50);
    end
    wr_reg(3'd4, 32'h4, 4'hF);
    rd_reg(3'd4, v);
    total++;
    if (v !== 32'h8) begin
      bad++; $display("FAIL to_w1c got=%h exp=%h", v, 32'h8);
    end
    seen = 1'b0;
    addr = 3'd4; rd = 1'b1;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(posedge clk); #1;
      if (rdata[2] === 1'b1) seen = 1'b1;
    end
    rd = 1'b0;
    total++;
    if (seen !== 1'b1) begin
      bad++; $display("FAIL to_second got=%b exp=1", seen);
    end
    // Next timeout lands 1000 edges after the one just observed.
    wait_cyc(998);
    wr_reg(3'd4, 32'h4, 4'hF);
    rd_reg(3'd4, v);
    total++;
    if (v !== 32'hC) begin
      bad++; $display("FAIL to_set_wins got=%h exp=%h", v, 32'hC);
    end
    wr_reg(3'd1, 32'h0, 4'hF);
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    wr_reg(3'd4, 32'hC, 4'hF);
    wr_reg(3'd1, 32'h1, 4'hF);
    wait_cyc(5);
    pin = 1'b1;
    wait_cyc(500);
    rst = 1'b1;
    pin = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(3);
    for (int a = 1; a <= 4; a++) begin
      rd_reg(3'(a), v);
      total++;
      if (v !== 32'd0) begin
        bad++; $display("FAIL rst_mid_addr%0d got=%h exp=%h", a, v, 32'd0);
      end
    end
    wr_reg(3'd1, 32'h1, 4'hF);
    wait_cyc(5);
    pin = 1'b1;
    wait_cyc(123);
    pin = 1'b0;
    wait_cyc(10);
    rd_reg(3'd2, v);
    total++;
    if (v !== 32'd123) begin
      bad++; $display("FAIL rst_mid_width got=%0d exp=%0d", v, 123);
    end
    rd_reg(3'd4, v);
    total++;
    if (v !== 32'h9) begin
      bad++; $display("FAIL rst_mid_status got=%h exp=%h", v, 32'h9);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_enable_high();
    test_measure();
    test_invert();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
